// File: rtl/duck_flight_ctrl.sv
// Duck sprite flight controller: frame-ticked motion FSM (fly, escape, hit, fall)
// that feeds position, image and visibility to the VGA stage through two strobes.
module duck_flight_ctrl #(
    parameter int START_X       = 304,
    parameter int START_Y       = 400,
    parameter int FLOOR_Y       = 400,
    parameter int MAX_X         = 608,
    parameter int DX            = 2,
    parameter int DY            = 2,
    parameter int FALL_DY       = 4,
    parameter int FLAP_FRAMES   = 8,
    parameter int HIT_FRAMES    = 30,
    parameter int ESCAPE_FRAMES = 600,
    parameter int SEL_FLAP0     = 0,
    parameter int SEL_FLAP1     = 1,
    parameter int SEL_HIT       = 2,
    parameter int SEL_FALL      = 3
) (
    input  logic       clk_25mhz,
    input  logic       rst,
    input  logic       vsync,
    input  logic       start,
    input  logic       hit,
    output logic [9:0] sprite_x,
    output logic [8:0] sprite_y,
    output logic [4:0] sprite_sel,
    output logic       sprite_vis,
    output logic       sprite_pos,
    output logic       sprite_attr,
    output logic       busy,
    output logic       downed,
    output logic       escaped
);

    typedef enum logic [2:0] {S_IDLE, S_FLY, S_ESCAPE, S_HIT, S_FALL} state_t;

    localparam int FLAP_W   = $clog2(FLAP_FRAMES + 1);
    localparam int HIT_W    = $clog2(HIT_FRAMES + 1);
    localparam int FLIGHT_W = $clog2(ESCAPE_FRAMES + 1);

    localparam logic signed [10:0] L_ZERO    = 11'sd0;
    localparam logic signed [10:0] L_DX      = 11'(DX);
    localparam logic signed [10:0] L_DY      = 11'(DY);
    localparam logic signed [10:0] L_FALL_DY = 11'(FALL_DY);
    localparam logic signed [10:0] L_MAX_X   = 11'(MAX_X);
    localparam logic signed [10:0] L_FLOOR_Y = 11'(FLOOR_Y);

    state_t                r_state, w_state;
    logic [9:0]            r_x, w_x;
    logic [8:0]            r_y, w_y;
    logic [4:0]            r_sel, w_sel;
    logic                  r_vis, w_vis;
    logic                  r_left, w_left;
    logic                  r_up, w_up;
    logic [FLAP_W-1:0]     r_flap, w_flap;
    logic [HIT_W-1:0]      r_hitcnt, w_hitcnt;
    logic [FLIGHT_W-1:0]   r_flight, w_flight;
    logic [2:0]            r_vs;
    logic                  r_pos, r_attr, r_pend;
    logic                  r_downed, w_downed;
    logic                  r_escaped, w_escaped;
    logic                  w_req, w_tick;
    logic                  w_flap_wrap;
    logic [4:0]            w_flap_sel;
    logic signed [10:0]    w_x_ext, w_y_ext;
    logic signed [10:0]    w_x_step, w_y_fly, w_y_esc, w_y_fall;

    // r_vs[0..1] is the two-flop synchroniser, r_vs[2] the delayed copy for edge detection.
    assign w_tick = r_vs[2] & ~r_vs[1];

    assign w_x_ext  = {1'b0, r_x};
    assign w_y_ext  = {2'b00, r_y};
    assign w_x_step = r_left ? (w_x_ext - L_DX) : (w_x_ext + L_DX);
    assign w_y_fly  = r_up ? (w_y_ext - L_DY) : (w_y_ext + L_DY);
    assign w_y_esc  = w_y_ext - L_DY;
    assign w_y_fall = w_y_ext + L_FALL_DY;

    assign w_flap_wrap = (r_flap == FLAP_W'(FLAP_FRAMES - 1));
    assign w_flap_sel  = (r_sel == 5'(SEL_FLAP0)) ? 5'(SEL_FLAP1) : 5'(SEL_FLAP0);

    always_comb begin
        // NOTE: every next-value signal takes its hold value first so no path infers a latch.
        w_state   = r_state;
        w_x       = r_x;
        w_y       = r_y;
        w_sel     = r_sel;
        w_vis     = r_vis;
        w_left    = r_left;
        w_up      = r_up;
        w_flap    = r_flap;
        w_hitcnt  = r_hitcnt;
        w_flight  = r_flight;
        w_downed  = 1'b0;
        w_escaped = 1'b0;
        w_req     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state  = S_FLY;
                    w_x      = 10'(START_X);
                    w_y      = 9'(START_Y);
                    w_left   = 1'b0;
                    w_up     = 1'b1;
                    w_sel    = 5'(SEL_FLAP0);
                    w_vis    = 1'b1;
                    w_flap   = '0;
                    w_hitcnt = '0;
                    w_flight = '0;
                    w_req    = 1'b1;
                end
            end
            S_FLY, S_ESCAPE: begin
                if (hit) begin
                    // A tick landing with the shot still strobes, but moves nothing.
                    w_state  = S_HIT;
                    w_sel    = 5'(SEL_HIT);
                    w_hitcnt = '0;
                    w_req    = w_tick;
                end else if (w_tick) begin
                    w_req  = 1'b1;
                    w_flap = w_flap_wrap ? '0 : r_flap + FLAP_W'(1);
                    if (w_flap_wrap)
                        w_sel = w_flap_sel;
                    if (r_state == S_FLY) begin
                        if (w_x_step > L_MAX_X) begin
                            w_x    = 10'(MAX_X);
                            w_left = 1'b1;
                        end else if (w_x_step < L_ZERO) begin
                            w_x    = '0;
                            w_left = 1'b0;
                        end else begin
                            w_x = w_x_step[9:0];
                        end
                        if (w_y_fly < L_ZERO) begin
                            w_y  = '0;
                            w_up = 1'b0;
                        end else if (w_y_fly > L_FLOOR_Y) begin
                            w_y  = 9'(FLOOR_Y);
                            w_up = 1'b1;
                        end else begin
                            w_y = w_y_fly[8:0];
                        end
                        if (r_flight == FLIGHT_W'(ESCAPE_FRAMES - 1))
                            w_state = S_ESCAPE;
                        else
                            w_flight = r_flight + FLIGHT_W'(1);
                    end else if (w_y_esc < L_ZERO) begin
                        w_y       = '0;
                        w_vis     = 1'b0;
                        w_escaped = 1'b1;
                        w_state   = S_IDLE;
                    end else begin
                        w_y = w_y_esc[8:0];
                    end
                end
            end
            S_HIT: begin
                if (w_tick) begin
                    w_req = 1'b1;
                    if (r_hitcnt == HIT_W'(HIT_FRAMES - 1)) begin
                        w_sel   = 5'(SEL_FALL);
                        w_state = S_FALL;
                    end else begin
                        w_hitcnt = r_hitcnt + HIT_W'(1);
                    end
                end
            end
            S_FALL: begin
                if (w_tick) begin
                    w_req = 1'b1;
                    if (w_y_fall >= L_FLOOR_Y) begin
                        w_y      = 9'(FLOOR_Y);
                        w_vis    = 1'b0;
                        w_downed = 1'b1;
                        w_state  = S_IDLE;
                    end else begin
                        w_y = w_y_fall[8:0];
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            // NOTE: vsync flops reset high (idle level) so releasing reset cannot fake a frame edge.
            r_vs      <= 3'b111;
            r_state   <= S_IDLE;
            r_x       <= 10'(START_X);
            r_y       <= 9'(START_Y);
            r_sel     <= 5'(SEL_FLAP0);
            r_vis     <= 1'b0;
            r_left    <= 1'b0;
            r_up      <= 1'b1;
            r_flap    <= '0;
            r_hitcnt  <= '0;
            r_flight  <= '0;
            r_pos     <= 1'b0;
            r_attr    <= 1'b0;
            r_pend    <= 1'b0;
            r_downed  <= 1'b0;
            r_escaped <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_vs      <= {r_vs[1:0], vsync};
            r_state   <= w_state;
            r_x       <= w_x;
            r_y       <= w_y;
            r_sel     <= w_sel;
            r_vis     <= w_vis;
            r_left    <= w_left;
            r_up      <= w_up;
            r_flap    <= w_flap;
            r_hitcnt  <= w_hitcnt;
            r_flight  <= w_flight;
            r_downed  <= w_downed;
            r_escaped <= w_escaped;
            // A load request arriving while sprite_attr is about to fire waits one cycle.
            r_pos     <= (w_req | r_pend) & ~r_pos;
            r_pend    <= (w_req | r_pend) & r_pos;
            r_attr    <= r_pos;
        end
    end

    assign sprite_x    = r_x;
    assign sprite_y    = r_y;
    assign sprite_sel  = r_sel;
    assign sprite_vis  = r_vis;
    assign sprite_pos  = r_pos;
    assign sprite_attr = r_attr;
    assign busy        = (r_state != S_IDLE);
    assign downed      = r_downed;
    assign escaped     = r_escaped;

endmodule

// File: doc/duck_flight_ctrl.md
DUCK_FLIGHT_CTRL -- requirements
Module: duck_flight_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- START_X, 304, spawn x
- START_Y, 400, spawn y (floor)
- FLOOR_Y, 400, lowest y
- MAX_X, 608, rightmost x (640 minus 32-pixel sprite)
- DX, 2, horizontal pixels per frame
- DY, 2, vertical pixels per frame
- FALL_DY, 4, falling pixels per frame
- FLAP_FRAMES, 8, frames per wing image
- HIT_FRAMES, 30, frames frozen after hit
- ESCAPE_FRAMES, 600, frames of flight before escape
- SEL_FLAP0, 0, first flap image index
- SEL_FLAP1, 1, second flap image index
- SEL_HIT, 2, hit image index
- SEL_FALL, 3, fall image index
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk_25mhz, in, 1, pixel clock; single clock domain
- rst, in, 1, asynchronous active-high reset
- vsync, in, 1, active-low vertical sync from the VGA stage; asynchronous
- start, in, 1, one-cycle launch request
- hit, in, 1, one-cycle shot-on-duck pulse
- sprite_x, out, 10, sprite column
- sprite_y, out, 9, sprite row
- sprite_sel, out, 5, sprite image index
- sprite_vis, out, 1, sprite visible
- sprite_pos, out, 1, one-cycle strobe that loads x/y/sel into the VGA stage
- sprite_attr, out, 1, one-cycle strobe that loads vis into the VGA stage
- busy, out, 1, duck active (state not IDLE)
- downed, out, 1, one-cycle pulse when the shot duck lands
- escaped, out, 1, one-cycle pulse when the duck leaves the top of the screen

Function
REQ-003 SHALL synchronise vsync through two flops and generate a one-cycle frame tick on each synchronised high-to-low edge.
REQ-004 SHALL implement the states IDLE, FLY, ESCAPE, HIT, FALL.
REQ-005 IDLE: on start, the block SHALL set x=START_X, y=START_Y, direction right/up, sel=SEL_FLAP0, vis=1, clear the frame counters, go to FLY, and issue sprite_pos then sprite_attr on the next two cycles.
REQ-006 FLY, per tick, horizontal: x±DX; a result above MAX_X SHALL clamp to MAX_X and reverse direction; a result below 0 SHALL clamp to 0 and reverse direction.
REQ-007 FLY, per tick, vertical: y±DY; a result below 0 SHALL clamp to 0 and turn downward; a result above FLOOR_Y SHALL clamp to FLOOR_Y and turn upward.
REQ-008 FLY and ESCAPE: sel SHALL toggle between SEL_FLAP0 and SEL_FLAP1 every FLAP_FRAMES ticks.
REQ-009 The flight counter SHALL increment per tick in FLY; on reaching ESCAPE_FRAMES the block SHALL enter ESCAPE.
REQ-010 ESCAPE: x SHALL hold and y SHALL decrease by DY per tick; when y would go below 0, the block SHALL set y=0, vis=0, pulse escaped, and enter IDLE.
REQ-011 hit in FLY or ESCAPE SHALL set sel=SEL_HIT and enter HIT; a simultaneous tick SHALL apply no motion in that cycle; hit in any other state SHALL be ignored.
REQ-012 HIT: position SHALL freeze for HIT_FRAMES ticks, then the block SHALL set sel=SEL_FALL and enter FALL.
REQ-013 FALL: y SHALL increase by FALL_DY per tick; on reaching or exceeding FLOOR_Y, the block SHALL clamp y to FLOOR_Y, set vis=0, pulse downed, and enter IDLE.
REQ-014 Every tick outside IDLE SHALL update registers on the edge after the tick, assert sprite_pos in the following cycle, and assert sprite_attr in the cycle after that; strobes SHALL never overlap.
REQ-015 start in any state other than IDLE SHALL be ignored; a tick in IDLE SHALL produce no strobes.
REQ-016 All arithmetic SHALL use 11-bit signed intermediates so that neither underflow nor overflow wraps.

Reset
REQ-017 On rst, all outputs SHALL immediately (asynchronously) take these values: sprite_x=START_X, sprite_y=START_Y, sprite_sel=SEL_FLAP0, sprite_vis=0, sprite_pos=sprite_attr=busy=downed=escaped=0, state=IDLE, counters=0.
REQ-018 Reset asserted mid-flight SHALL abandon the flight with no strobe and no pulse; after release the block SHALL wait for start.

Verification
REQ-019 start, then one vsync fall -> x=306, y=398; sprite_pos one cycle, then sprite_attr one cycle.
REQ-020 Preload x=607 moving right, then a tick -> x=608 and direction left; next tick -> x=606.
REQ-021 hit coincident with a tick at x=306, y=398 -> position unchanged, sel=2; after 30 ticks sel=3; y steps by 4 until 400, then downed pulses once and vis=0.
REQ-022 600 ticks with no hit -> ESCAPE; y decreases by 2 per tick to 0; escaped pulses once; busy=0.
REQ-023 rst pulsed during FALL -> outputs match REQ-017 immediately; no downed pulse.
REQ-024 start during FLY, and hit during IDLE -> no state change.
